// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath: widths, reset PC and fetch states.
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W  = 8;
   localparam int unsigned CPU_INSTR_W = 8;
   localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: branch_pc + 1 + sign-extended offset, carry discarded.
module branch_target_calc
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = CPU_ADDR_W
) (
   input  logic [ADDR_W-1:0] i_branch_pc,
   input  logic [ADDR_W-1:0] i_branch_offset,
   output logic [ADDR_W-1:0] o_target
);

   // Offset is already sign-extended, so modular addition handles negative values.
   assign o_target = i_branch_pc + ADDR_W'(1) + i_branch_offset;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one req/ack transaction per
// instruction and holds the fetched word in a valid/ready buffer for decode.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = CPU_ADDR_W,
   parameter int unsigned       INSTR_W  = CPU_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_imem_req,
   output logic [ADDR_W-1:0]  o_imem_addr,
   input  logic               i_imem_ack,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   output logic               o_instr_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_instr_pc,
   input  logic               i_instr_ready,
   input  logic               i_branch_taken,
   input  logic [ADDR_W-1:0]  i_branch_pc,
   input  logic [ADDR_W-1:0]  i_branch_offset,
   input  logic               i_halt
);

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_req_addr;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic               r_flush_q;
   logic               r_halt_q;
   logic [ADDR_W-1:0]  w_target;

   branch_target_calc #(
      .ADDR_W (ADDR_W)
   ) u_branch_target_calc (
      .i_branch_pc     (i_branch_pc),
      .i_branch_offset (i_branch_offset),
      .o_target        (w_target)
   );

   // Handshake outputs come from the state register only; no input-to-output path.
   assign o_imem_req    = (r_state == FETCH);
   assign o_instr_valid = (r_state == HOLD);
   assign o_imem_addr   = r_req_addr;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;

   // Fetch FSM with PC, request address, instruction buffer and flush/halt flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_flush_q  <= 1'b0;
         r_halt_q   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_halt) begin
                  r_state <= HALT;
               end else if (i_branch_taken) begin
                  r_pc       <= w_target;
                  r_req_addr <= w_target;
                  r_state    <= FETCH;
               end else begin
                  r_req_addr <= r_pc;
                  r_state    <= FETCH;
               end
            end
            FETCH: begin
               if (i_halt || r_halt_q) begin
                  // The outstanding transaction must finish before fetching stops.
                  if (i_imem_ack) begin
                     r_state <= HALT;
                  end else begin
                     r_halt_q <= 1'b1;
                  end
               end else if (i_branch_taken) begin
                  r_pc <= w_target;
                  if (i_imem_ack) begin
                     r_req_addr <= w_target;
                     r_flush_q  <= 1'b0;
                  end else begin
                     // Keep req_addr stable until the in-flight ack returns.
                     r_flush_q <= 1'b1;
                  end
               end else if (i_imem_ack) begin
                  if (r_flush_q) begin
                     r_flush_q  <= 1'b0;
                     r_req_addr <= r_pc;
                  end else begin
                     r_instr    <= i_imem_rdata;
                     r_instr_pc <= r_req_addr;
                     r_pc       <= r_req_addr + ADDR_W'(1);
                     r_state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (i_halt) begin
                  r_state <= HALT;
               end else if (i_branch_taken) begin
                  r_pc       <= w_target;
                  r_req_addr <= w_target;
                  r_state    <= FETCH;
               end else if (i_instr_ready) begin
                  r_req_addr <= r_pc;
                  r_state    <= FETCH;
               end
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected instructions,
// negedge monitors pop and compare on every decode acceptance.
module tb_fetch_unit;

   typedef struct packed {
      logic [7:0] instr;
      logic [7:0] pc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_pass   = 0;

   // Main DUT (RESET_PC = 0x00)
   logic       rst = 1'b1;
   logic       imem_req, imem_ack, instr_valid, instr_ready, branch_taken, halt;
   logic [7:0] imem_addr, imem_rdata, instr, instr_pc, branch_pc, branch_offset;

   // Wrap DUT (RESET_PC = 0xFF)
   logic       wr_rst = 1'b1;
   logic       wr_req, wr_ack, wr_valid, wr_ready, wr_branch, wr_halt;
   logic [7:0] wr_addr, wr_rdata, wr_instr, wr_instr_pc, wr_bpc, wr_boff;

   exp_t q[$];
   exp_t wq[$];

   logic [7:0] mem [256];
   int         ack_delay = 0;
   int         wait_cnt  = 0;

   fetch_unit #(
      .ADDR_W   (8),
      .INSTR_W  (8),
      .RESET_PC (8'h00)
   ) u_dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_ack      (imem_ack),
      .i_imem_rdata    (imem_rdata),
      .o_instr_valid   (instr_valid),
      .o_instr         (instr),
      .o_instr_pc      (instr_pc),
      .i_instr_ready   (instr_ready),
      .i_branch_taken  (branch_taken),
      .i_branch_pc     (branch_pc),
      .i_branch_offset (branch_offset),
      .i_halt          (halt)
   );

   fetch_unit #(
      .ADDR_W   (8),
      .INSTR_W  (8),
      .RESET_PC (8'hFF)
   ) u_wrap (
      .i_clk           (clk),
      .i_rst           (wr_rst),
      .o_imem_req      (wr_req),
      .o_imem_addr     (wr_addr),
      .i_imem_ack      (wr_ack),
      .i_imem_rdata    (wr_rdata),
      .o_instr_valid   (wr_valid),
      .o_instr         (wr_instr),
      .o_instr_pc      (wr_instr_pc),
      .i_instr_ready   (wr_ready),
      .i_branch_taken  (wr_branch),
      .i_branch_pc     (wr_bpc),
      .i_branch_offset (wr_boff),
      .i_halt          (wr_halt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model for the main DUT: ack after ack_delay idle cycles, one-cycle pulse.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      forever begin
         step();
         if (rst || imem_ack || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end else if (wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
         end else begin
            wait_cnt++;
         end
      end
   end

   // Main monitor: every decode acceptance must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready && !branch_taken && !halt) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_instr: got instr %0h pc %0h, expected none", instr,
                     instr_pc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("instr", {24'h0, instr}, {24'h0, e.instr});
            check("instr_pc", {24'h0, instr_pc}, {24'h0, e.pc});
         end
      end
   end

   // Wrap monitor.
   always @(negedge clk) begin
      if (!wr_rst && wr_valid && wr_ready && !wr_branch && !wr_halt) begin
         if (wq.size() == 0) begin
            n_checks++;
            $display("FAIL wrap_unexpected_instr: got instr %0h pc %0h, expected none",
                     wr_instr, wr_instr_pc);
         end else begin
            exp_t e;
            e = wq.pop_front();
            check("wrap_instr", {24'h0, wr_instr}, {24'h0, e.instr});
            check("wrap_instr_pc", {24'h0, wr_instr_pc}, {24'h0, e.pc});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int c1;
      bit seen;
      c0 = -1;
      c1 = -1;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'hA1;
      mem[8'h01] = 8'hB2;
      mem[8'h02] = 8'hC3;
      mem[8'h0D] = 8'hD4;
      mem[8'h0E] = 8'hEE;
      mem[8'h24] = 8'hE5;
      instr_ready = 1'b1; branch_taken = 1'b0; branch_pc = 8'h00; branch_offset = 8'h00;
      halt = 1'b0;
      wr_ack = 1'b0; wr_rdata = 8'h00; wr_ready = 1'b0; wr_branch = 1'b0;
      wr_bpc = 8'h00; wr_boff = 8'h00; wr_halt = 1'b0;

      // Reset values
      step();
      step();
      check("rst_imem_req", {31'h0, imem_req}, 0);
      check("rst_imem_addr", {24'h0, imem_addr}, 0);
      check("rst_instr_valid", {31'h0, instr_valid}, 0);
      check("rst_instr", {24'h0, instr}, 0);
      check("rst_instr_pc", {24'h0, instr_pc}, 0);
      check("rst_wrap_imem_addr", {24'h0, wr_addr}, 32'hFF);
      check("rst_wrap_imem_req", {31'h0, wr_req}, 0);

      // Zero-wait streaming; stall once 0x01 is held
      q.push_back('{instr: 8'hA1, pc: 8'h00});
      q.push_back('{instr: 8'hB2, pc: 8'h01});
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (instr_valid && instr_pc == 8'h00 && c0 < 0) c0 = cyc;
         if (instr_valid && instr_pc == 8'h01) begin
            c1 = cyc;
            instr_ready = 1'b0;
            break;
         end
      end
      check("stream_valid_spacing", c1 - c0, 2);

      // Back-pressure: buffer stable, no request, no PC advance
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'h0, instr_valid}, 1);
         check("bp_instr", {24'h0, instr}, 32'hB2);
         check("bp_instr_pc", {24'h0, instr_pc}, 1);
         check("bp_imem_req", {31'h0, imem_req}, 0);
         step();
      end
      instr_ready = 1'b1;
      step();
      check("bp_next_req", {31'h0, imem_req}, 1);
      check("bp_next_addr", {24'h0, imem_addr}, 2);
      instr_ready = 1'b0;

      // Branch in HOLD: 0x10 + 1 - 4 = 0x0D, held 0xC3 dropped
      step();
      check("hold_valid", {31'h0, instr_valid}, 1);
      check("hold_instr_pc", {24'h0, instr_pc}, 2);
      branch_taken = 1'b1; branch_pc = 8'h10; branch_offset = 8'hFC;
      step();
      branch_taken = 1'b0;
      check("brh_imem_req", {31'h0, imem_req}, 1);
      check("brh_imem_addr", {24'h0, imem_addr}, 32'h0D);
      check("brh_valid", {31'h0, instr_valid}, 0);
      q.push_back('{instr: 8'hD4, pc: 8'h0D});
      instr_ready = 1'b1;
      step();
      check("brh_fetched_valid", {31'h0, instr_valid}, 1);
      ack_delay = 3;

      // Branch during a pending fetch: 0x20 + 1 + 3 = 0x24, 0x0E data discarded
      step();
      check("pend_addr", {24'h0, imem_addr}, 32'h0E);
      branch_taken = 1'b1; branch_pc = 8'h20; branch_offset = 8'h03;
      step();
      branch_taken = 1'b0;
      check("pend_addr_held", {24'h0, imem_addr}, 32'h0E);
      check("pend_req_held", {31'h0, imem_req}, 1);
      q.push_back('{instr: 8'hE5, pc: 8'h24});
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (imem_addr == 8'h24) begin
            seen = 1'b1;
            break;
         end
      end
      check("pend_redirect_seen", {31'h0, seen}, 1);
      check("pend_redirect_req", {31'h0, imem_req}, 1);
      check("pend_no_valid", {31'h0, instr_valid}, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (instr_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("pend_target_fetched", {31'h0, seen}, 1);
      ack_delay = 100;

      // Reset asserted mid-FETCH
      step();
      check("mid_req", {31'h0, imem_req}, 1);
      check("mid_addr", {24'h0, imem_addr}, 32'h25);
      step();
      rst = 1'b1;
      #1;
      check("mid_rst_req", {31'h0, imem_req}, 0);
      check("mid_rst_addr", {24'h0, imem_addr}, 0);
      check("mid_rst_instr", {24'h0, instr}, 0);
      check("mid_rst_instr_pc", {24'h0, instr_pc}, 0);
      ack_delay = 2;
      step();
      step();
      rst = 1'b0;

      // Halt during FETCH, ack two cycles later
      step();
      check("halt_fetch_req", {31'h0, imem_req}, 1);
      check("halt_fetch_addr", {24'h0, imem_addr}, 0);
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_pending_req", {31'h0, imem_req}, 1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!imem_req) begin
            seen = 1'b1;
            break;
         end
      end
      check("halt_req_dropped", {31'h0, seen}, 1);
      for (int i = 0; i < 6; i++) begin
         check("halt_req_low", {31'h0, imem_req}, 0);
         check("halt_valid_low", {31'h0, instr_valid}, 0);
         step();
      end

      // Wrap DUT: 0xFF + 1 = 0x00, then branch 0xFE + 1 + 3 = 0x02
      wr_rst = 1'b0;
      step();
      check("wrap_req", {31'h0, wr_req}, 1);
      check("wrap_addr", {24'h0, wr_addr}, 32'hFF);
      wr_ack = 1'b1; wr_rdata = 8'h5A;
      wq.push_back('{instr: 8'h5A, pc: 8'hFF});
      step();
      wr_ack = 1'b0;
      check("wrap_valid", {31'h0, wr_valid}, 1);
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      check("wrap_next_req", {31'h0, wr_req}, 1);
      check("wrap_next_addr", {24'h0, wr_addr}, 0);
      wr_branch = 1'b1; wr_bpc = 8'hFE; wr_boff = 8'h03;
      step();
      wr_branch = 1'b0;
      check("wrap_flush_addr_held", {24'h0, wr_addr}, 0);
      wr_ack = 1'b1; wr_rdata = 8'h77;
      step();
      wr_ack = 1'b0;
      check("wrap_target_addr", {24'h0, wr_addr}, 32'h02);
      check("wrap_target_req", {31'h0, wr_req}, 1);
      check("wrap_flush_no_valid", {31'h0, wr_valid}, 0);
      step();

      check("main_queue_empty", q.size(), 0);
      check("wrap_queue_empty", wq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
